register_dump_unit: RTL and testbench

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

---
 rtl/register_dump_unit.sv | 100 ++++++++++
 tb/tb_register_dump_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_unit.sv
// Streams every word of a register bank out as bytes, MSB first, over a
// valid/ready byte interface, then pulses o_done.
module register_dump_unit #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_read_reg,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned NumBytes = NB_DATA / NB_BYTE;
  localparam int unsigned NbCnt    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [NB_REG-1:0] LastReg  = '1;
  localparam logic [NbCnt-1:0]  LastByte = NbCnt'(NumBytes - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StNext,
    StDone
  } state_t;

  state_t             state;
  logic [NbCnt-1:0]   byte_cnt;
  logic [NB_DATA-1:0] shift_reg;

  assign o_tx_data = shift_reg[NB_DATA-1 -: NB_BYTE];

  // Flag outputs are registered alongside the state and always reflect the
  // state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= StIdle;
      o_read_reg <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (i_start) begin
            o_read_reg <= '0;
            o_busy     <= 1'b1;
            state      <= StLoad;
          end
        end
        StLoad: begin
          // Word is snapshotted here; later bank writes do not reach the stream.
          shift_reg  <= i_reg_data;
          byte_cnt   <= '0;
          o_tx_valid <= 1'b1;
          state      <= StSend;
        end
        StSend: begin
          if (i_tx_ready) begin
            if (byte_cnt == LastByte) begin
              o_tx_valid <= 1'b0;
              state      <= StNext;
            end else begin
              shift_reg <= shift_reg << NB_BYTE;
              byte_cnt  <= byte_cnt + 1'b1;
            end
          end
        end
        StNext: begin
          if (o_read_reg == LastReg) begin
            o_done <= 1'b1;
            state  <= StDone;
          end else begin
            o_read_reg <= o_read_reg + 1'b1;
            state      <= StLoad;
          end
        end
        StDone: begin
          o_busy <= 1'b0;
          state  <= StIdle;
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: full dumps, backpressure, ignored
// restarts, snapshot behaviour and resets.
module tb_register_dump_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [4:0]  o_read_reg;
  logic [31:0] i_reg_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] bank     [32];
  logic [31:0] exp_bank [32];

  int checks = 0;
  int errors = 0;

  logic [7:0] xfers[$];
  logic [7:0] data_log  [256];
  logic       valid_log [256];
  logic       busy_log  [256];
  logic [4:0] reg_log   [256];
  int         done_cycle;
  int         done_count;

  assign i_reg_data = bank[o_read_reg];

  always #5 i_clk = ~i_clk;

  register_dump_unit dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_read_reg (o_read_reg),
    .i_reg_data (i_reg_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = exp_bank[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  // Index of the first transfer that differs from the model, -1 if none.
  function automatic int seq_mismatch();
    if (xfers.size() != 128) return xfers.size();
    for (int i = 0; i < 128; i++) if (xfers[i] !== exp_byte(i)) return i;
    return -1;
  endfunction

  task automatic set_bank_default();
    for (int k = 0; k < 32; k++) bank[k] = 32'(k) * 32'h0101_0101;
  endtask

  // Start pulse sampled at edge 0; cycle c is the period after edge c-1.
  task automatic run_dump(input int stall_from, input int stall_len, input int restart_cycle,
                          input int write_cycle, input logic [31:0] write_val);
    exp_bank = bank;
    xfers.delete();
    done_cycle = -1;
    done_count = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int c = 1; c <= 210; c++) begin
      @(negedge i_clk);
      i_start    = (c == restart_cycle);
      i_tx_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (c == write_cycle) bank[3] = write_val;
      if (o_tx_valid && i_tx_ready) xfers.push_back(o_tx_data);
      if (o_done) begin
        done_count++;
        done_cycle = c;
      end
      data_log[c]  = o_tx_data;
      valid_log[c] = o_tx_valid;
      busy_log[c]  = o_busy;
      reg_log[c]   = o_read_reg;
    end
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_start = 1'b1;
    i_tx_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_read_reg !== 5'd0) begin
      errors++; $display("FAIL reset_read_reg got %h want 00", o_read_reg);
    end
    checks++;
    if (o_tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data got %h want 00", o_tx_data);
    end
    checks++;
    if (o_tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid got %b want 0", o_tx_valid);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", o_busy);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", o_done);
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_full_dump();
    int bad;
    int busy_bad;
    set_bank_default();
    run_dump(-1, 0, -1, -1, 32'h0);
    bad = seq_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL full_seq first bad index %0d (count %0d) want 128 in order", bad,
                         xfers.size());
    end
    checks++;
    if (done_cycle != 193 || done_count != 1) begin
      errors++; $display("FAIL full_done cycle %0d count %0d want 193/1", done_cycle, done_count);
    end
    busy_bad = -1;
    for (int c = 1; c <= 210; c++)
      if (busy_log[c] !== (c <= 193) && busy_bad < 0) busy_bad = c;
    checks++;
    if (busy_bad != -1) begin
      errors++; $display("FAIL full_busy wrong at cycle %0d want high 1..193", busy_bad);
    end
    checks++;
    if (valid_log[1] !== 1'b0 || valid_log[2] !== 1'b1 || valid_log[6] !== 1'b0) begin
      errors++; $display("FAIL full_valid_timing got c1=%b c2=%b c6=%b want 0 1 0",
                         valid_log[1], valid_log[2], valid_log[6]);
    end
    checks++;
    if (reg_log[6] !== 5'd0 || reg_log[7] !== 5'd1 || reg_log[193] !== 5'd31) begin
      errors++; $display("FAIL full_read_reg got c6=%0d c7=%0d c193=%0d want 0 1 31",
                         reg_log[6], reg_log[7], reg_log[193]);
    end
  endtask

  task automatic test_deadbeef();
    set_bank_default();
    bank[5] = 32'hDEAD_BEEF;
    run_dump(-1, 0, -1, -1, 32'h0);
    checks++;
    if (xfers.size() < 24 || xfers[20] !== 8'hDE || xfers[21] !== 8'hAD ||
        xfers[22] !== 8'hBE || xfers[23] !== 8'hEF) begin
      errors++; $display("FAIL deadbeef_bytes got %h %h %h %h want DE AD BE EF",
                         xfers[20], xfers[21], xfers[22], xfers[23]);
    end
  endtask

  task automatic test_stall();
    int bad;
    logic stable;
    set_bank_default();
    bank[0] = 32'h1122_3344;
    run_dump(4, 3, -1, -1, 32'h0);
    stable = 1'b1;
    for (int c = 4; c <= 7; c++)
      if (valid_log[c] !== 1'b1 || data_log[c] !== 8'h33) stable = 1'b0;
    checks++;
    if (!stable) begin
      errors++; $display("FAIL stall_hold got %h %h %h %h want 33 x4 with valid",
                         data_log[4], data_log[5], data_log[6], data_log[7]);
    end
    bad = seq_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL stall_seq first bad index %0d want -1", bad);
    end
    checks++;
    if (done_cycle != 196 || done_count != 1) begin
      errors++; $display("FAIL stall_done cycle %0d count %0d want 196/1", done_cycle, done_count);
    end
  endtask

  task automatic test_restart_ignored();
    int bad;
    set_bank_default();
    run_dump(-1, 0, 50, -1, 32'h0);
    bad = seq_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL restart_seq first bad index %0d want -1", bad);
    end
    checks++;
    if (done_cycle != 193 || done_count != 1) begin
      errors++; $display("FAIL restart_done cycle %0d count %0d want 193/1", done_cycle,
                         done_count);
    end
  endtask

  task automatic test_bank_write();
    int bad;
    set_bank_default();
    run_dump(-1, 0, -1, 21, 32'hCAFE_F00D);
    bad = seq_mismatch();
    checks++;
    if (bad != -1) begin
      errors++; $display("FAIL snapshot_seq first bad index %0d got %h want %h", bad,
                         (bad >= 0 && bad < xfers.size()) ? xfers[bad] : 8'hxx, exp_byte(bad));
    end
  endtask

  task automatic test_mid_reset();
    int xc;
    int rc;
    int dones;
    int bad;
    set_bank_default();
    xc = 0;
    rc = -1;
    dones = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_done) dones++;
      if (c == rc + 1 && rc > 0) begin
        checks++;
        if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_read_reg !== 5'd0) begin
          errors++; $display("FAIL midreset_outputs got valid=%b busy=%b reg=%0d want 0 0 0",
                             o_tx_valid, o_busy, o_read_reg);
        end
        i_reset = 1'b0;
      end
      if (c == rc) i_reset = 1'b1;
      if (rc < 0 && o_tx_valid && i_tx_ready) begin
        xc++;
        if (xc == 50) rc = c + 1;
      end
    end
    checks++;
    if (dones != 0 || rc < 0) begin
      errors++; $display("FAIL midreset_no_done got dones=%0d rc=%0d want 0 and reset applied",
                         dones, rc);
    end
    run_dump(-1, 0, -1, -1, 32'h0);
    bad = seq_mismatch();
    checks++;
    if (bad != -1 || xfers[0] !== 8'h00) begin
      errors++; $display("FAIL midreset_restart first bad index %0d want -1", bad);
    end
    checks++;
    if (done_cycle != 193) begin
      errors++; $display("FAIL midreset_done cycle %0d want 193", done_cycle);
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
    set_bank_default();
    test_reset();
    test_full_dump();
    test_deadbeef();
    test_stall();
    test_restart_ignored();
    test_bank_write();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
